// File: rtl/pipe_ctrl_pkg.sv
// pipe_ctrl_pkg: shared stage indices, bus width and multi-cycle FSM encoding
package pipe_ctrl_pkg;
  localparam int STALL_W = 6;
  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  typedef enum logic {MC_IDLE = 1'b0, MC_BUSY = 1'b1} mc_state_e;
endpackage

// File: rtl/pipe_ctrl_mc_timer.sv
// mc_timer: latency counter and IDLE/BUSY FSM for multi-cycle EX operations
import pipe_ctrl_pkg::*;
module mc_timer #(
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] cycles,
  input  logic             kill,
  output logic             hold,
  output logic             done
);
  mc_state_e state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= MC_IDLE;
      cnt   <= '0;
    end else begin
      state <= state_n;
      cnt   <= cnt_n;
    end
  end
  // kill (flush) and rst both discard any op in flight or being issued
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    hold    = 1'b0;
    done    = 1'b0;
    if (rst || kill) begin
      state_n = MC_IDLE;
      cnt_n   = '0;
    end else if (state == MC_IDLE) begin
      if (start && cycles <= CNT_W'(1)) done = 1'b1;
      else if (start) begin
        hold    = 1'b1;
        state_n = MC_BUSY;
        cnt_n   = cycles - CNT_W'(1);
      end
    end else begin
      cnt_n   = cnt - CNT_W'(1);
      hold    = cnt > CNT_W'(1);
      done    = cnt == CNT_W'(1);
      state_n = cnt > CNT_W'(1) ? MC_BUSY : MC_IDLE;
    end
  end
endmodule

// File: rtl/pipe_ctrl.sv
// pipe_ctrl: merges stall requests into a thermometer stall vector, applies flushes with PC redirect, and runs the deadlock watchdog
import pipe_ctrl_pkg::*;
module pipe_ctrl #(
  parameter int STAGES    = STALL_W,
  parameter int EX_IDX    = STG_EX,
  parameter int FLUSH_IDX = STG_MEM,
  parameter int CNT_W     = 6,
  parameter int TIMEOUT   = 1024
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [STAGES-1:0] stallreq,
  input  logic              mc_start,
  input  logic [CNT_W-1:0]  mc_cycles,
  output logic              mc_done,
  input  logic              flush_req,
  input  logic [31:0]       flush_pc,
  output logic [STAGES-1:0] stall,
  output logic [STAGES-1:0] flush,
  output logic              redirect_valid,
  output logic [31:0]       redirect_pc,
  output logic              deadlock
);
  localparam int SW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1;
  logic              mc_hold;
  logic [STAGES-1:0] req;
  logic [SW-1:0]     scnt, scnt_n;
  mc_timer #(.CNT_W(CNT_W)) u_mc_timer (
    .clk    (clk),
    .rst    (rst),
    .start  (mc_start),
    .cycles (mc_cycles),
    .kill   (flush_req),
    .hold   (mc_hold),
    .done   (mc_done)
  );
  assign req = stallreq | (STAGES'(mc_hold) << EX_IDX);
  // stage i stalls when it or any younger-facing later stage requests a hold
  always_comb begin
    stall = '0;
    flush = '0;
    for (int i = 0; i < STAGES; i++) begin
      stall[i] = !rst && !flush_req && |(req >> i);
      flush[i] = !rst && flush_req && i <= FLUSH_IDX;
    end
  end
  assign scnt_n = !stall[0] ? '0 : scnt != SW'(TIMEOUT) ? scnt + SW'(1) : scnt;
  always_ff @(posedge clk) begin
    if (rst) begin
      redirect_valid <= 1'b0;
      redirect_pc    <= '0;
      scnt           <= '0;
      deadlock       <= 1'b0;
    end else begin
      redirect_valid <= flush_req;
      if (flush_req) redirect_pc <= flush_pc;
      scnt <= scnt_n;
      if (TIMEOUT != 0 && scnt_n == SW'(TIMEOUT)) deadlock <= 1'b1;
    end
  end
endmodule

// File: tb/tb_pipe_ctrl.sv
// tb_pipe_ctrl: directed scenario tests for pipe_ctrl with TIMEOUT shortened to 8
module tb_pipe_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  stallreq;
  logic        mc_start;
  logic [5:0]  mc_cycles;
  logic        mc_done;
  logic        flush_req;
  logic [31:0] flush_pc;
  logic [5:0]  stall;
  logic [5:0]  flush;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        deadlock;
  int tests = 0;
  int fails = 0;

  pipe_ctrl #(.TIMEOUT(8)) dut (
    .clk(clk), .rst(rst), .stallreq(stallreq), .mc_start(mc_start),
    .mc_cycles(mc_cycles), .mc_done(mc_done), .flush_req(flush_req),
    .flush_pc(flush_pc), .stall(stall), .flush(flush),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc), .deadlock(deadlock)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #1;
  endtask

  task automatic idle_inputs();
    stallreq = '0; mc_start = 0; mc_cycles = '0; flush_req = 0; flush_pc = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    mc_start = 1; mc_cycles = 6'd4; stallreq = 6'b100000; flush_req = 1;
    step(); settle();
    tests++; if (stall !== 6'b0) begin fails++; $display("FAIL reset_stall got %b exp 000000", stall); end
    tests++; if (flush !== 6'b0) begin fails++; $display("FAIL reset_flush got %b exp 000000", flush); end
    tests++; if (mc_done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", mc_done); end
    idle_inputs();
    step();
    tests++; if (redirect_valid !== 1'b0 || redirect_pc !== 32'h0 || deadlock !== 1'b0) begin
      fails++; $display("FAIL reset_regs got rv=%b pc=%h dl=%b exp 0 0 0", redirect_valid, redirect_pc, deadlock); end
    rst = 0;
    step();
  endtask

  task automatic test_load_use();
    stallreq = 6'b000100;
    for (int i = 0; i < 3; i++) begin
      settle();
      tests++; if (stall !== 6'b000111 || flush !== 6'b0) begin
        fails++; $display("FAIL load_use c%0d got stall=%b flush=%b exp 000111 000000", i, stall, flush); end
      step();
    end
    stallreq = 6'b100000; settle();
    tests++; if (stall !== 6'b111111) begin fails++; $display("FAIL wb_req got %b exp 111111", stall); end
    stallreq = 6'b000001; settle();
    tests++; if (stall !== 6'b000001) begin fails++; $display("FAIL pc_req got %b exp 000001", stall); end
    stallreq = 6'b0; settle();
    tests++; if (stall !== 6'b0) begin fails++; $display("FAIL no_req got %b exp 000000", stall); end
    step();
  endtask

  task automatic test_multicycle();
    mc_start = 1; mc_cycles = 6'd4;
    for (int c = 1; c <= 4; c++) begin
      settle();
      if (c < 4) begin
        tests++; if (stall !== 6'b001111 || mc_done !== 1'b0) begin
          fails++; $display("FAIL mc4 c%0d got stall=%b done=%b exp 001111 0", c, stall, mc_done); end
      end else begin
        tests++; if (stall !== 6'b0 || mc_done !== 1'b1) begin
          fails++; $display("FAIL mc4 c%0d got stall=%b done=%b exp 000000 1", c, stall, mc_done); end
      end
      step();
      mc_start = 0;
    end
  endtask

  task automatic test_back_to_back();
    mc_start = 1; mc_cycles = 6'd2; settle();
    tests++; if (stall !== 6'b001111 || mc_done !== 1'b0) begin
      fails++; $display("FAIL b2b_first got stall=%b done=%b exp 001111 0", stall, mc_done); end
    step(); mc_start = 0; settle();
    tests++; if (stall !== 6'b0 || mc_done !== 1'b1) begin
      fails++; $display("FAIL b2b_done got stall=%b done=%b exp 000000 1", stall, mc_done); end
    step(); mc_start = 1; mc_cycles = 6'd2; settle();
    tests++; if (stall !== 6'b001111 || mc_done !== 1'b0) begin
      fails++; $display("FAIL b2b_second got stall=%b done=%b exp 001111 0", stall, mc_done); end
    step(); mc_start = 0; settle();
    tests++; if (mc_done !== 1'b1) begin fails++; $display("FAIL b2b_done2 got %b exp 1", mc_done); end
    step();
  endtask

  task automatic test_single_cycle();
    for (int n = 0; n < 2; n++) begin
      mc_start = 1; mc_cycles = 6'(n); settle();
      tests++; if (stall !== 6'b0 || mc_done !== 1'b1) begin
        fails++; $display("FAIL mc_n%0d got stall=%b done=%b exp 000000 1", n, stall, mc_done); end
      step(); mc_start = 0; settle();
      tests++; if (stall !== 6'b0 || mc_done !== 1'b0) begin
        fails++; $display("FAIL mc_n%0d_after got stall=%b done=%b exp 000000 0", n, stall, mc_done); end
      step();
    end
  endtask

  task automatic test_flush();
    mc_start = 1; mc_cycles = 6'd4;
    step(); mc_start = 0;
    step();
    flush_req = 1; flush_pc = 32'hBFC00380; stallreq = 6'b000100; settle();
    tests++; if (flush !== 6'b011111 || stall !== 6'b0 || mc_done !== 1'b0) begin
      fails++; $display("FAIL flush_apply got flush=%b stall=%b done=%b exp 011111 000000 0", flush, stall, mc_done); end
    step(); flush_req = 0; flush_pc = '0; stallreq = '0; settle();
    tests++; if (redirect_valid !== 1'b1 || redirect_pc !== 32'hBFC00380) begin
      fails++; $display("FAIL redirect got rv=%b pc=%h exp 1 bfc00380", redirect_valid, redirect_pc); end
    tests++; if (stall !== 6'b0 || mc_done !== 1'b0 || flush !== 6'b0) begin
      fails++; $display("FAIL flush_idle got stall=%b done=%b flush=%b exp 0 0 0", stall, mc_done, flush); end
    step();
    tests++; if (redirect_valid !== 1'b0) begin fails++; $display("FAIL redirect_clear got %b exp 0", redirect_valid); end
    mc_start = 1; mc_cycles = 6'd3; flush_req = 1; flush_pc = 32'h80000180; settle();
    tests++; if (stall !== 6'b0 || mc_done !== 1'b0) begin
      fails++; $display("FAIL flush_vs_start got stall=%b done=%b exp 000000 0", stall, mc_done); end
    step(); mc_start = 0; flush_req = 0; settle();
    tests++; if (stall !== 6'b0 || redirect_pc !== 32'h80000180) begin
      fails++; $display("FAIL start_discarded got stall=%b pc=%h exp 000000 80000180", stall, redirect_pc); end
    step();
  endtask

  task automatic test_reset_mid_busy();
    mc_start = 1; mc_cycles = 6'd5;
    step(); mc_start = 0;
    rst = 1; settle();
    tests++; if (stall !== 6'b0 || mc_done !== 1'b0) begin
      fails++; $display("FAIL rst_busy got stall=%b done=%b exp 000000 0", stall, mc_done); end
    step(); rst = 0;
    mc_start = 1; mc_cycles = 6'd3; settle();
    tests++; if (stall !== 6'b001111) begin fails++; $display("FAIL rst_mc3_c1 got %b exp 001111", stall); end
    step(); mc_start = 0; settle();
    tests++; if (stall !== 6'b001111 || mc_done !== 1'b0) begin
      fails++; $display("FAIL rst_mc3_c2 got stall=%b done=%b exp 001111 0", stall, mc_done); end
    step(); settle();
    tests++; if (stall !== 6'b0 || mc_done !== 1'b1) begin
      fails++; $display("FAIL rst_mc3_c3 got stall=%b done=%b exp 000000 1", stall, mc_done); end
    step();
  endtask

  task automatic test_deadlock();
    rst = 1; step(); rst = 0;
    stallreq = 6'b000010;
    for (int i = 1; i <= 8; i++) begin
      step();
      if (i == 7) begin
        tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL dl_early got %b exp 0", deadlock); end
      end
    end
    tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL dl_rise got %b exp 1", deadlock); end
    stallreq = '0;
    step(); step();
    tests++; if (deadlock !== 1'b1) begin fails++; $display("FAIL dl_sticky got %b exp 1", deadlock); end
    rst = 1; step(); rst = 0;
    tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL dl_reset got %b exp 0", deadlock); end
    stallreq = 6'b000010;
    for (int i = 0; i < 5; i++) step();
    stallreq = '0; step();
    stallreq = 6'b000010;
    for (int i = 0; i < 5; i++) step();
    tests++; if (deadlock !== 1'b0) begin fails++; $display("FAIL dl_gap got %b exp 0", deadlock); end
    stallreq = '0; step();
  endtask

  initial begin
    idle_inputs();
    rst = 1;
    #1;
    test_reset();
    test_load_use();
    test_multicycle();
    test_back_to_back();
    test_single_cycle();
    test_flush();
    test_reset_mid_busy();
    test_deadlock();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
